// File: rtl/mips32_pkg.sv
// Shared types and constants for the MIPS32 data-memory responder.
package mips32_pkg;

    localparam int MEM_DEPTH = 1024;
    localparam int WORD_W    = 32;
    localparam int CNT_W     = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    function automatic logic addr_in_range(
        input logic [WORD_W-1:0] addr,
        input int unsigned       depth
    );
        return addr < depth;
    endfunction

endpackage

// File: rtl/mips32_sram.sv
// Single-port word SRAM: synchronous write, registered synchronous read.
module mips32_sram
    import mips32_pkg::*;
#(
    parameter int DEPTH = MEM_DEPTH,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] rdata_q;

    // Read data only moves on a read access, so it holds during a response.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem_q[addr] <= wdata;
            end else begin
                rdata_q <= mem_q[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mips32_mem_resp.sv
// Latency-configurable memory responder with valid/ready request and response.
module mips32_mem_resp
    import mips32_pkg::*;
#(
    parameter int LATENCY = 2,
    parameter int DEPTH   = MEM_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT =
        (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [WORD_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic              rd_q, rd_d;

    logic              accept;
    logic              go_resp;
    logic              acc_we;
    logic [WORD_W-1:0] acc_addr;
    logic [WORD_W-1:0] acc_wdata;
    logic              acc_ok;
    logic              sram_en;
    logic [WORD_W-1:0] sram_rdata;

    // With zero latency the access happens on the accept edge itself,
    // so the live request is used before it has been latched.
    always_comb begin
        accept    = req_valid && req_ready_q;
        acc_we    = (state_q == IDLE) ? req_we    : we_q;
        acc_addr  = (state_q == IDLE) ? req_addr  : addr_q;
        acc_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
        acc_ok    = addr_in_range(acc_addr, DEPTH);
        go_resp   = ((state_q == IDLE) && accept && (LATENCY == 0))
                 || ((state_q == WAIT) && (cnt_q == '0));
        sram_en   = go_resp && acc_ok && rst_n;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rd_d        = rd_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    we_d        = req_we;
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    req_ready_d = 1'b0;
                    state_d     = WAIT;
                    cnt_d       = CNT_INIT;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    req_ready_d = 1'b1;
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rd_d        = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
                rsp_err_d   = 1'b0;
                rd_d        = 1'b0;
            end
        endcase
        if (go_resp) begin
            state_d     = RESP;
            cnt_d       = '0;
            rsp_valid_d = 1'b1;
            rsp_err_d   = !acc_ok;
            rd_d        = acc_ok && !acc_we;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rd_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rd_q        <= rd_d;
        end
    end

    mips32_sram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_sram (
        .clk   (clk),
        .en    (sram_en),
        .we    (acc_we),
        .addr  (acc_addr[AW-1:0]),
        .wdata (acc_wdata),
        .rdata (sram_rdata)
    );

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rd_q ? sram_rdata : '0;

endmodule

// File: tb/tb_mips32_mem_resp.sv
// Scoreboard bench for mips32_mem_resp at LATENCY=2 and LATENCY=0.
module tb_mips32_mem_resp;

    localparam int LAT = 2;
    localparam int DEP = 1024;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic        z_req_valid, z_req_ready, z_req_we;
    logic [31:0] z_req_addr, z_req_wdata;
    logic        z_rsp_valid, z_rsp_ready, z_rsp_err;
    logic [31:0] z_rsp_rdata;

    exp_t        sb[$];
    logic [31:0] model [DEP];
    int          total = 0;
    int          passed = 0;

    always #5 clk = ~clk;

    mips32_mem_resp #(.LATENCY(LAT), .DEPTH(DEP)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    mips32_mem_resp #(.LATENCY(0), .DEPTH(DEP)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
        .req_addr(z_req_addr), .req_wdata(z_req_wdata),
        .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
        .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
    );

    // Drive one request, scramble the inputs after accept, push expectation.
    task automatic issue(input txn_t t, output bit ok);
        exp_t e;
        int   n;
        req_valid = 1'b1;
        req_we    = t.we;
        req_addr  = t.addr;
        req_wdata = t.data;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        ok = (req_ready === 1'b1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_we    = ~t.we;
        req_addr  = t.addr ^ 32'h1;
        req_wdata = ~t.data;
        e.err   = (t.addr >= DEP);
        e.rdata = '0;
        if (t.we && !e.err) model[t.addr[9:0]] = t.data;
        else if (!t.we && !e.err) e.rdata = model[t.addr[9:0]];
        sb.push_back(e);
    endtask

    task automatic wait_rsp(output int cyc);
        cyc = 1;
        while (rsp_valid !== 1'b1 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; rsp_ready = 0;
        z_req_valid = 0; z_req_we = 0; z_req_addr = 0; z_req_wdata = 0;
        z_rsp_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (req_ready !== 1'b1) $display("FAIL rst_req_ready got %b want 1", req_ready); else passed++;
        total++; if (rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid got %b want 0", rsp_valid); else passed++;
        total++; if (rsp_rdata !== 32'h0) $display("FAIL rst_rsp_rdata got %h want 0", rsp_rdata); else passed++;
        total++; if (rsp_err !== 1'b0) $display("FAIL rst_rsp_err got %b want 0", rsp_err); else passed++;
        total++; if (z_req_ready !== 1'b1) $display("FAIL rst_z_req_ready got %b want 1", z_req_ready); else passed++;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_store_load();
        txn_t tv[6];
        exp_t e;
        bit   ok;
        int   cyc;
        tv = '{'{1'b1, 32'd5,  32'hDEADBEEF}, '{1'b0, 32'd5,  32'h0},
               '{1'b1, 32'd7,  32'h000000AA}, '{1'b1, 32'd20, 32'h00000077},
               '{1'b1, 32'd8,  32'h00000088}, '{1'b1, 32'd9,  32'h00001111}};
        foreach (tv[i]) begin
            issue(tv[i], ok);
            wait_rsp(cyc);
            e = sb.pop_front();
            total++; if (!ok) $display("FAIL sl_accept[%0d] req_ready not seen", i); else passed++;
            total++; if (cyc != LAT + 1) $display("FAIL sl_latency[%0d] got %0d want %0d", i, cyc, LAT + 1); else passed++;
            total++; if (rsp_rdata !== e.rdata) $display("FAIL sl_rdata[%0d] got %h want %h", i, rsp_rdata, e.rdata); else passed++;
            total++; if (rsp_err !== e.err) $display("FAIL sl_err[%0d] got %b want %b", i, rsp_err, e.err); else passed++;
            finish_rsp();
            total++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) $display("FAIL sl_idle[%0d] valid=%b ready=%b want 0/1", i, rsp_valid, req_ready); else passed++;
        end
    endtask

    task automatic test_input_change();
        txn_t tv[3];
        exp_t e;
        bit   ok;
        int   cyc;
        tv = '{'{1'b0, 32'd9, 32'h0}, '{1'b0, 32'd8, 32'h0},
               '{1'b0, 32'd5, 32'h0}};
        foreach (tv[i]) begin
            issue(tv[i], ok);
            wait_rsp(cyc);
            e = sb.pop_front();
            total++; if (!ok) $display("FAIL ic_accept[%0d] req_ready not seen", i); else passed++;
            total++; if (cyc != LAT + 1) $display("FAIL ic_latency[%0d] got %0d want %0d", i, cyc, LAT + 1); else passed++;
            total++; if (rsp_rdata !== e.rdata) $display("FAIL ic_rdata[%0d] got %h want %h", i, rsp_rdata, e.rdata); else passed++;
            total++; if (rsp_err !== e.err) $display("FAIL ic_err[%0d] got %b want %b", i, rsp_err, e.err); else passed++;
            finish_rsp();
        end
    endtask

    task automatic test_out_of_range();
        txn_t tv[7];
        exp_t e;
        bit   ok;
        int   cyc;
        tv = '{'{1'b1, 32'd0,         32'h12345678},
               '{1'b1, 32'd1023,      32'h0000A5A5},
               '{1'b1, 32'd1024,      32'h00000001},
               '{1'b1, 32'h80000000,  32'h00000001},
               '{1'b0, 32'd0,         32'h0},
               '{1'b0, 32'd1023,      32'h0},
               '{1'b0, 32'h00010005,  32'h0}};
        foreach (tv[i]) begin
            issue(tv[i], ok);
            wait_rsp(cyc);
            e = sb.pop_front();
            total++; if (!ok) $display("FAIL oor_accept[%0d] req_ready not seen", i); else passed++;
            total++; if (cyc != LAT + 1) $display("FAIL oor_latency[%0d] got %0d want %0d", i, cyc, LAT + 1); else passed++;
            total++; if (rsp_rdata !== e.rdata) $display("FAIL oor_rdata[%0d] got %h want %h", i, rsp_rdata, e.rdata); else passed++;
            total++; if (rsp_err !== e.err) $display("FAIL oor_err[%0d] got %b want %b", i, rsp_err, e.err); else passed++;
            finish_rsp();
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        bit   ok;
        int   cyc;
        issue('{1'b0, 32'd20, 32'h0}, ok);
        wait_rsp(cyc);
        e = sb.pop_front();
        total++; if (cyc != LAT + 1) $display("FAIL bp_latency got %0d want %0d", cyc, LAT + 1); else passed++;
        for (int h = 0; h < 5; h++) begin
            total++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== e.rdata ||
                rsp_err !== e.err || req_ready !== 1'b0)
                $display("FAIL bp_hold[%0d] valid=%b rdata=%h ready=%b want 1/%h/0",
                         h, rsp_valid, rsp_rdata, req_ready, e.rdata);
            else passed++;
            @(posedge clk); #1;
        end
        finish_rsp();
        total++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) $display("FAIL bp_release valid=%b ready=%b want 0/1", rsp_valid, req_ready); else passed++;
        total++; if (rsp_rdata !== 32'h0) $display("FAIL bp_idle_rdata got %h want 0", rsp_rdata); else passed++;
    endtask

    task automatic test_reset_wait();
        exp_t e;
        bit   ok;
        int   cyc;
        bit   seen;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'd7; req_wdata = 32'h55;
        total++; if (req_ready !== 1'b1) $display("FAIL rw_ready got %b want 1", req_ready); else passed++;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        total++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) $display("FAIL rw_abort ready=%b valid=%b want 1/0", req_ready, rsp_valid); else passed++;
        seen = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b0) seen = 1'b1;
        end
        total++; if (seen) $display("FAIL rw_no_rsp got response want none"); else passed++;
        issue('{1'b0, 32'd7, 32'h0}, ok);
        wait_rsp(cyc);
        e = sb.pop_front();
        total++; if (cyc != LAT + 1) $display("FAIL rw_latency got %0d want %0d", cyc, LAT + 1); else passed++;
        total++; if (rsp_rdata !== e.rdata) $display("FAIL rw_rdata got %h want %h", rsp_rdata, e.rdata); else passed++;
        finish_rsp();
    endtask

    task automatic test_back_to_back_lat0();
        txn_t        tv[4];
        logic [31:0] zm[2];
        exp_t        e;
        tv = '{'{1'b1, 32'd0, 32'hCAFE0000}, '{1'b1, 32'd1, 32'h0BADF00D},
               '{1'b0, 32'd0, 32'h0},        '{1'b0, 32'd1, 32'h0}};
        zm[0] = '0;
        zm[1] = '0;
        z_rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++; if (z_req_ready !== 1'b1) $display("FAIL z_ready[%0d] got %b want 1", i, z_req_ready); else passed++;
            z_req_valid = 1'b1;
            z_req_we    = tv[i].we;
            z_req_addr  = tv[i].addr;
            z_req_wdata = tv[i].data;
            e.err   = 1'b0;
            e.rdata = tv[i].we ? 32'h0 : zm[tv[i].addr[0]];
            if (tv[i].we) zm[tv[i].addr[0]] = tv[i].data;
            sb.push_back(e);
            @(posedge clk); #1;
            e = sb.pop_front();
            total++; if (z_rsp_valid !== 1'b1) $display("FAIL z_valid[%0d] got %b want 1", i, z_rsp_valid); else passed++;
            total++; if (z_req_ready !== 1'b0) $display("FAIL z_busy[%0d] got %b want 0", i, z_req_ready); else passed++;
            total++; if (z_rsp_rdata !== e.rdata) $display("FAIL z_rdata[%0d] got %h want %h", i, z_rsp_rdata, e.rdata); else passed++;
            total++; if (z_rsp_err !== e.err) $display("FAIL z_err[%0d] got %b want %b", i, z_rsp_err, e.err); else passed++;
            @(posedge clk); #1;
        end
        z_req_valid = 1'b0;
        z_rsp_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_input_change();
        test_out_of_range();
        test_backpressure();
        test_reset_wait();
        test_back_to_back_lat0();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mips32_mem_resp.md
MIPS32_MEM_RESP -- requirements
Module: mips32_mem_resp

Interface
REQ-001 SHALL have parameter LATENCY, default 2, meaning wait cycles between request accept and response (legal 0..15).
REQ-002 SHALL have parameter DEPTH, default 1024, meaning number of 32-bit words stored.
REQ-003 SHALL have port clk  input  1  meaning single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n  input  1  meaning reset, synchronous, active-low.
REQ-005 SHALL have port req_valid  input  1  meaning the initiator presents a request.
REQ-006 SHALL have port req_ready  output  1  meaning the responder can accept a request.
REQ-007 SHALL have port req_we  input  1  meaning 1 = store (SW), 0 = load (LW).
REQ-008 SHALL have port req_addr  input  32  meaning word address, indexed the same way as the core's Mem[] array (not a byte address).
REQ-009 SHALL have port req_wdata  input  32  meaning store data.
REQ-010 SHALL have port rsp_valid  output  1  meaning a response is presented.
REQ-011 SHALL have port rsp_ready  input  1  meaning the initiator accepts the response.
REQ-012 SHALL have port rsp_rdata  output  32  meaning load data (0 for stores and errors).
REQ-013 SHALL have port rsp_err  output  1  meaning the address was out of range.

Function
REQ-014 SHALL implement the FSM states IDLE, WAIT and RESP.
REQ-015 SHALL assert req_ready only in IDLE; a request is accepted when req_valid and req_ready are both 1 on a clock edge.
REQ-016 SHALL latch we, addr and wdata on accept; later changes on the req_* inputs SHALL have no effect on the accepted request.
REQ-017 On accept with LATENCY>0, SHALL enter WAIT with a down-counter loaded to LATENCY-1.
REQ-018 SHALL leave WAIT for RESP when the counter is 0; otherwise it SHALL decrement the counter.
REQ-019 On accept with LATENCY=0, SHALL go directly to RESP; rsp_valid SHALL then be 1 in the cycle after accept.
REQ-020 Total latency SHALL be LATENCY+1 cycles from the accept edge to the first cycle with rsp_valid=1.
REQ-021 SHALL perform the array access (read sample or write commit) exactly once, on the edge that enters RESP.
REQ-022 SHALL treat an address as out of range when req_addr >= DEPTH, including any nonzero upper bits.
REQ-023 An out-of-range store SHALL not modify the array; an out-of-range request SHALL respond with rsp_err=1 and rsp_rdata=0.
REQ-024 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL be held stable until rsp_ready=1.
REQ-025 When rsp_valid and rsp_ready are both 1, SHALL return to IDLE; req_ready SHALL be 1 in the following cycle (no accept in the same cycle).
REQ-026 A load SHALL observe all previously responded stores (read-after-write through the array).
REQ-027 Outside RESP, rsp_valid SHALL be 0 and rsp_rdata/rsp_err SHALL be 0.

Reset
REQ-028 While rst_n=0 at a clock edge: state SHALL be IDLE, counter 0, req_ready 1 after the edge, rsp_valid 0, rsp_rdata 0, rsp_err 0.
REQ-029 Reset in WAIT SHALL abort the request; a pending store SHALL not be committed.
REQ-030 Reset SHALL not clear array contents.

Structure
REQ-031 SHALL take the state enum (IDLE/WAIT/RESP), MEM_DEPTH=1024, WORD_W=32 and CNT_W=4 from shared package mips32_pkg.
REQ-032 SHALL instantiate one sub-module mips32_sram: DEPTH x 32, synchronous write and synchronous read, single port.

Verification
REQ-033 Store then load: SW addr 5 data 0xDEADBEEF, then LW addr 5 -> rsp_rdata=0xDEADBEEF, rsp_err=0, each response 3 cycles after accept (LATENCY=2).
REQ-034 LATENCY=0 build: LW addr 0 -> rsp_valid=1 in the cycle after accept; back-to-back requests are accepted every 2 cycles with rsp_ready held at 1.
REQ-035 Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stay stable and req_ready=0 throughout; rsp_ready=1 -> IDLE on the next edge.
REQ-036 Out of range: SW addr 1024 data 0x1, then SW addr 0x80000000 -> rsp_err=1 for both and no word of the array changes; LW addr 1023 -> err=0.
REQ-037 Reset mid-WAIT: SW addr 7 data 0x55 with rst_n pulsed low 1 cycle after accept -> no response; a later LW addr 7 returns the prior value.
REQ-038 Input change after accept: alter req_addr/req_wdata during WAIT -> the committed store uses the latched values.
